// File: rtl/sdram_pkg.sv
// SDRAM arbiter shared types: FSM states, command encodings, bus bundle.
// Imported by the init/aref/write/read command generators and the arbiter.
package sdram_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_ARBIT,
    S_AREF,
    S_WRITE,
    S_READ
  } state_t;

  typedef enum logic {
    LG_WRITE = 1'b0,
    LG_READ  = 1'b1
  } grant_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
  } sdram_bus_t;

  localparam sdram_bus_t BUS_IDLE = '{
    cmd:  CMD_NOP,
    ba:   2'b11,
    addr: 13'h1fff
  };

endpackage

// File: rtl/sdram_arbit.sv
// Arbiter between SDRAM init, refresh, write and read command generators.
// Owns the SDRAM command pins; one grant at a time, with a grant timeout.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int DQ_W    = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            init_end,
  input  logic [3:0]      init_cmd,
  input  logic [1:0]      init_ba,
  input  logic [12:0]     init_addr,
  input  logic            aref_req,
  input  logic            aref_end,
  input  logic [3:0]      aref_cmd,
  input  logic [1:0]      aref_ba,
  input  logic [12:0]     aref_addr,
  input  logic            wr_req,
  input  logic            wr_end,
  input  logic [3:0]      wr_cmd,
  input  logic [1:0]      wr_ba,
  input  logic [12:0]     wr_addr,
  input  logic            wr_sdram_en,
  input  logic [DQ_W-1:0] wr_sdram_data,
  input  logic            rd_req,
  input  logic            rd_end,
  input  logic [3:0]      rd_cmd,
  input  logic [1:0]      rd_ba,
  input  logic [12:0]     rd_addr,
  output logic            aref_en,
  output logic            wr_en,
  output logic            rd_en,
  output logic            sdram_cke,
  output logic            sdram_cs_n,
  output logic            sdram_ras_n,
  output logic            sdram_cas_n,
  output logic            sdram_we_n,
  output logic [1:0]      sdram_ba,
  output logic [12:0]     sdram_addr,
  output logic [DQ_W-1:0] sdram_dq_out,
  output logic            sdram_dq_oe,
  output logic            arb_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t     state;
  state_t     state_nxt;
  grant_t     last_grant;
  logic [CW-1:0] cnt;
  logic       expire;
  logic       to_hit;
  logic       grant_now;
  logic       granted;
  sdram_bus_t bus;

  assign expire    = (cnt == CW'(TIMEOUT - 1));
  assign granted   = (state == S_AREF) || (state == S_WRITE)
                  || (state == S_READ);
  assign grant_now = (state == S_ARBIT) && (state_nxt != S_ARBIT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_INIT;
      last_grant <= LG_READ;
      cnt        <= '0;
      arb_err    <= 1'b0;
      sdram_cke  <= 1'b0;
    end else begin
      state     <= state_nxt;
      sdram_cke <= 1'b1;
      if (to_hit)
        arb_err <= 1'b1;
      if (grant_now)
        cnt <= '0;
      else if (granted)
        cnt <= cnt + 1'b1;
      if (grant_now && state_nxt == S_WRITE)
        last_grant <= LG_WRITE;
      else if (grant_now && state_nxt == S_READ)
        last_grant <= LG_READ;
    end
  end

  always_comb begin
    state_nxt = state;
    to_hit    = 1'b0;
    unique case (state)
      S_INIT:
        if (init_end)
          state_nxt = S_ARBIT;
      S_ARBIT:
        if (aref_req)
          state_nxt = S_AREF;
        else if (wr_req && (!rd_req || last_grant == LG_READ))
          state_nxt = S_WRITE;
        else if (rd_req)
          state_nxt = S_READ;
      S_AREF:
        if (aref_end)
          state_nxt = S_ARBIT;
        else if (expire) begin
          state_nxt = S_ARBIT;
          to_hit    = 1'b1;
        end
      S_WRITE:
        if (wr_end)
          state_nxt = S_ARBIT;
        else if (expire) begin
          state_nxt = S_ARBIT;
          to_hit    = 1'b1;
        end
      S_READ:
        if (rd_end)
          state_nxt = S_ARBIT;
        else if (expire) begin
          state_nxt = S_ARBIT;
          to_hit    = 1'b1;
        end
      default:
        state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    aref_en      = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    sdram_dq_oe  = 1'b0;
    sdram_dq_out = '0;
    bus          = BUS_IDLE;
    unique case (state)
      S_INIT:
        bus = '{init_cmd, init_ba, init_addr};
      S_AREF: begin
        aref_en = 1'b1;
        bus     = '{aref_cmd, aref_ba, aref_addr};
      end
      S_WRITE: begin
        wr_en        = 1'b1;
        bus          = '{wr_cmd, wr_ba, wr_addr};
        sdram_dq_oe  = wr_sdram_en;
        sdram_dq_out = wr_sdram_data;
      end
      S_READ: begin
        rd_en = 1'b1;
        bus   = '{rd_cmd, rd_ba, rd_addr};
      end
      default:
        bus = BUS_IDLE;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = bus.cmd;
  assign sdram_ba   = bus.ba;
  assign sdram_addr = bus.addr;

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: grant order/timing, write data window,
// timeout recovery and asynchronous reset.
module tb_sdram_arbit;

  localparam int DQ_W = 16;
  localparam int TO   = 32;

  localparam logic [2:0] G_AREF = 3'b100;
  localparam logic [2:0] G_WR   = 3'b010;
  localparam logic [2:0] G_RD   = 3'b001;

  localparam logic [18:0] B_INIT = {4'b0010, 2'b00, 13'h0400};
  localparam logic [18:0] B_AREF = {4'b0001, 2'b01, 13'h0011};
  localparam logic [18:0] B_WR   = {4'b0100, 2'b10, 13'h0123};
  localparam logic [18:0] B_RD   = {4'b0101, 2'b01, 13'h0456};
  localparam logic [18:0] B_NOP  = {4'b0111, 2'b11, 13'h1fff};

  logic            sys_clk = 1'b0;
  logic            sys_rst_n;
  logic            init_end, aref_req, aref_end;
  logic            wr_req, wr_end, rd_req, rd_end;
  logic            wr_sdram_en;
  logic [DQ_W-1:0] wr_sdram_data;
  logic            aref_en, wr_en, rd_en;
  logic            sdram_cke, sdram_cs_n, sdram_ras_n;
  logic            sdram_cas_n, sdram_we_n;
  logic [1:0]      sdram_ba;
  logic [12:0]     sdram_addr;
  logic [DQ_W-1:0] sdram_dq_out;
  logic            sdram_dq_oe;
  logic            arb_err;

  sdram_arbit #(.DQ_W(DQ_W), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .init_end(init_end),
    .init_cmd(B_INIT[18:15]), .init_ba(B_INIT[14:13]),
    .init_addr(B_INIT[12:0]),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(B_AREF[18:15]), .aref_ba(B_AREF[14:13]),
    .aref_addr(B_AREF[12:0]),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(B_WR[18:15]), .wr_ba(B_WR[14:13]),
    .wr_addr(B_WR[12:0]),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(B_RD[18:15]), .rd_ba(B_RD[14:13]),
    .rd_addr(B_RD[12:0]),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n),
    .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out),
    .sdram_dq_oe(sdram_dq_oe), .arb_err(arb_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [2:0] g;
    int         cyc;
  } exp_t;

  exp_t            gq[$];
  logic [DQ_W-1:0] dq[$];
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  logic [2:0]      prev_g = 3'b000;

  wire [18:0] bus = {sdram_cs_n, sdram_ras_n, sdram_cas_n,
                     sdram_we_n, sdram_ba, sdram_addr};
  wire [2:0]  g   = {aref_en, wr_en, rd_en};

  always @(posedge sys_clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic exp_grant(logic [2:0] gr, int c);
    exp_t e;
    e.g   = gr;
    e.cyc = c;
    gq.push_back(e);
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_g = 3'b000;
    end else begin
      chk("onehot_grant", {31'd0, $onehot0(g)}, 32'd1);
      if (g != 3'b000 && g != prev_g) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", {29'd0, g}, 32'd0);
        end else begin
          exp_t e;
          e = gq.pop_front();
          chk("grant_kind", {29'd0, g}, {29'd0, e.g});
          chk("grant_cycle", cyc, e.cyc);
        end
      end
      if (sdram_dq_oe) begin
        if (dq.size() == 0)
          chk("extra_dq_oe", 32'd1, 32'd0);
        else
          chk("dq_data", {16'd0, sdram_dq_out},
              {16'd0, dq.pop_front()});
      end
      prev_g = g;
    end
  end

  int c, w, r, w2, t, x;

  initial begin
    sys_rst_n = 1'b0;
    init_end = 0; aref_req = 0; aref_end = 0;
    wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
    wr_sdram_en = 0; wr_sdram_data = '0;
    #3;
    chk("rst_grants", {29'd0, g}, 32'd0);
    chk("rst_cke", {31'd0, sdram_cke}, 32'd0);
    chk("rst_err", {31'd0, arb_err}, 32'd0);
    chk("rst_oe", {31'd0, sdram_dq_oe}, 32'd0);
    chk("rst_bus_init", {13'd0, bus}, {13'd0, B_INIT});
    tick(2);
    sys_rst_n = 1'b1;
    while (cyc < 50) tick(1);
    chk("init_bus_c50", {13'd0, bus}, {13'd0, B_INIT});
    init_end = 1;
    tick(1);
    chk("nop_bus_c51", {13'd0, bus}, {13'd0, B_NOP});
    chk("cke_on", {31'd0, sdram_cke}, 32'd1);
    init_end = 0;

    // all three request: refresh, then write, then read
    c = cyc;
    aref_req = 1; wr_req = 1; rd_req = 1;
    exp_grant(G_AREF, c + 1);
    tick(1);
    aref_req = 0;
    chk("aref_bus", {13'd0, bus}, {13'd0, B_AREF});
    tick(9);
    aref_end = 1;
    tick(1);
    aref_end = 0;
    chk("aref_released", {31'd0, aref_en}, 32'd0);
    chk("arbit_nop", {13'd0, bus}, {13'd0, B_NOP});
    exp_grant(G_WR, c + 12);
    tick(1);
    w = cyc;
    wr_req = 0;
    chk("wr_bus", {13'd0, bus}, {13'd0, B_WR});
    for (int k = 0; k < 8; k++) begin
      wr_sdram_en   = 1;
      wr_sdram_data = 16'hA000 + 16'(k * 17);
      dq.push_back(wr_sdram_data);
      rd_end = (k == 3);
      tick(1);
    end
    wr_sdram_en = 0; wr_sdram_data = '0; rd_end = 0;
    chk("wr_held_past_rd_end", {31'd0, wr_en}, 32'd1);
    wr_end = 1;
    exp_grant(G_RD, w + 10);
    tick(1);
    wr_end = 0;
    chk("wr_released", {31'd0, wr_en}, 32'd0);
    tick(1);
    r = cyc;
    rd_req = 0;
    chk("rd_bus", {13'd0, bus}, {13'd0, B_RD});

    // write waiting through a read burst
    tick(2);
    wr_req = 1;
    tick(3);
    rd_end = 1;
    exp_grant(G_WR, r + 7);
    tick(1);
    rd_end = 0;
    chk("gap_no_grant", {29'd0, g}, 32'd0);
    tick(1);
    w2 = cyc;
    wr_req = 0;

    // refresh raised mid-write does not preempt
    tick(1);
    aref_req = 1; rd_req = 1;
    tick(2);
    chk("no_preempt", {29'd0, g}, {29'd0, G_WR});
    wr_end = 1;
    exp_grant(G_AREF, w2 + 5);
    tick(1);
    wr_end = 0;
    tick(1);
    aref_req = 0;
    tick(1);
    aref_end = 1;
    exp_grant(G_RD, w2 + 8);
    tick(1);
    aref_end = 0;
    tick(1);
    t = cyc;
    rd_req = 0;

    // read never ends: forced release after TO cycles
    chk("err_before_to", {31'd0, arb_err}, 32'd0);
    tick(5);
    wr_req = 1;
    tick(26);
    chk("rd_held_last", {31'd0, rd_en}, 32'd1);
    chk("err_last_cycle", {31'd0, arb_err}, 32'd0);
    exp_grant(G_WR, t + 33);
    tick(1);
    chk("rd_forced_off", {31'd0, rd_en}, 32'd0);
    chk("err_set", {31'd0, arb_err}, 32'd1);
    chk("to_arbit_nop", {13'd0, bus}, {13'd0, B_NOP});
    tick(1);
    wr_req = 0;
    chk("wr_after_to", {31'd0, wr_en}, 32'd1);
    tick(2);
    wr_end = 1;
    tick(1);
    wr_end = 0;
    chk("err_sticky", {31'd0, arb_err}, 32'd1);
    chk("wr_done", {31'd0, wr_en}, 32'd0);

    // reset in the middle of a write
    tick(2);
    x = cyc;
    wr_req = 1;
    exp_grant(G_WR, x + 1);
    tick(1);
    wr_req = 0;
    wr_sdram_en = 1; wr_sdram_data = 16'h5A5A;
    dq.push_back(16'h5A5A);
    tick(1);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_grants", {29'd0, g}, 32'd0);
    chk("mid_rst_cke", {31'd0, sdram_cke}, 32'd0);
    chk("mid_rst_err", {31'd0, arb_err}, 32'd0);
    chk("mid_rst_oe", {31'd0, sdram_dq_oe}, 32'd0);
    chk("mid_rst_dq", {16'd0, sdram_dq_out}, 32'd0);
    chk("mid_rst_bus", {13'd0, bus}, {13'd0, B_INIT});
    wr_sdram_en = 0; wr_sdram_data = '0;
    tick(2);
    sys_rst_n = 1'b1;
    wr_end = 1;
    tick(1);
    wr_end = 0;
    wr_req = 1;
    tick(3);
    chk("post_rst_init", {13'd0, bus}, {13'd0, B_INIT});
    chk("post_rst_no_wr", {31'd0, wr_en}, 32'd0);
    wr_req = 0;
    tick(2);
    chk("grants_left", gq.size(), 32'd0);
    chk("data_left", dq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameter DQ_W, default 16, SDRAM data width.
REQ-002 Parameter TIMEOUT, default 1024, maximum cycles a grant may be held before forced release.
REQ-003 Clock and reset: the block SHALL have one clock, sys_clk; reset sys_rst_n is asynchronous and active-low.
REQ-004 sys_clk  in  1  system clock; all state changes on its rising edge.
REQ-005 sys_rst_n  in  1  asynchronous active-low reset.
REQ-006 init_end  in  1  power-up init done, level.
REQ-007 init_cmd/init_ba/init_addr  in  4/2/13  init module command bus.
REQ-008 aref_req, aref_end  in  1 each  refresh request (level until granted), refresh done pulse.
REQ-009 aref_cmd/aref_ba/aref_addr  in  4/2/13  refresh command bus.
REQ-010 wr_req, wr_end  in  1 each  write request from fifo_ctrl path (level), write burst done pulse.
REQ-011 wr_cmd/wr_ba/wr_addr  in  4/2/13  write module command bus.
REQ-012 wr_sdram_en, wr_sdram_data  in  1/DQ_W  write data valid and data.
REQ-013 rd_req, rd_end  in  1 each  read request (level), read burst done pulse.
REQ-014 rd_cmd/rd_ba/rd_addr  in  4/2/13  read module command bus.
REQ-015 aref_en, wr_en, rd_en  out  1 each  grant to refresh/write/read module.
REQ-016 sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  SDRAM control pins.
REQ-017 sdram_ba/sdram_addr  out  2/13  SDRAM bank and address.
REQ-018 sdram_dq_out/sdram_dq_oe  out  DQ_W/1  write data and output enable for top-level tristate.
REQ-019 arb_err  out  1  sticky grant-timeout flag.

Function
REQ-020 The block SHALL implement states INIT, ARBIT, AREF, WRITE, READ, and SHALL hold at most one grant at any time.
REQ-021 INIT->ARBIT on the first cycle init_end=1; afterwards init_end is ignored.
REQ-022 ARBIT priority: aref_req wins over wr_req and rd_req.
REQ-023 With only one of wr_req and rd_req high, that request wins.
REQ-024 With both wr_req and rd_req high (no aref_req), the one not granted last wins (last_grant flag, reset value READ, so write wins first).
REQ-025 Entering AREF/WRITE/READ sets the matching *_en to 1 on the same clock edge.
REQ-026 *_en clears on the edge where the matching *_end=1, and state returns to ARBIT on that edge.
REQ-027 No preemption: aref_req raised during WRITE/READ waits for ARBIT.
REQ-028 Back-to-back operation: a request present in ARBIT is granted one cycle after the previous *_end.
REQ-029 Command mux, combinational on state: INIT->init bus, AREF->aref bus, WRITE->wr bus, READ->rd bus.
REQ-030 Command mux in ARBIT: cmd 4'b0111 (NOP), ba 2'b11, addr 13'h1FFF.
REQ-031 {cs_n,ras_n,cas_n,we_n} SHALL equal cmd[3:0]; sdram_cke SHALL be 1 after reset release.
REQ-032 sdram_dq_oe = wr_sdram_en only in WRITE, else 0; sdram_dq_out = wr_sdram_data in WRITE, else 0.
REQ-033 Timeout counter clears on each grant and counts while granted.
REQ-034 Reaching TIMEOUT-1 without *_end SHALL clear the grant, force ARBIT and set arb_err until reset.
REQ-035 *_end from a non-granted source SHALL be ignored.

Reset
REQ-036 Asynchronous reset SHALL force: state INIT, all *_en 0, last_grant READ, counter 0, arb_err 0, sdram_cke 0.
REQ-037 Reset mid-burst SHALL abandon the operation with no completion signalled.

Structure
REQ-038 Package sdram_pkg SHALL hold the state enum and command constants (NOP, PRE, AREF, ACT, WR, RD, MRS) shared with the init/aref/write/read modules.
REQ-039 Single module, no sub-modules; state and counter registered, command mux combinational.

Verification
REQ-040 init_end=1 at cycle 50 -> NOP bus from cycle 51, no *_en before.
REQ-041 aref_req, wr_req, rd_req all high in ARBIT -> aref_en first.
REQ-042 Same case, aref_end after 10 cycles -> aref_en first, then wr_en, then rd_en after wr_end.
REQ-043 wr_req held during a read burst -> wr_en exactly one cycle after rd_end.
REQ-044 Write burst of 8 words -> sdram_dq_oe high exactly 8 cycles with data matching wr_sdram_data.
REQ-045 Grant with no *_end for TIMEOUT cycles -> arb_err=1, state ARBIT, next request granted.
REQ-046 sys_rst_n low mid-WRITE -> all outputs at reset values immediately.
